// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one serial_tx byte transmitter among N_REQ requesters.
// A grant pulses tx_new_data, then the FSM follows tx_busy until the frame ends;
// the winner may keep the grant for up to MAX_BURST consecutive bytes.
module serial_tx_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned MAX_BURST    = 1,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    enable,
  input  logic [N_REQ-1:0]                        req_valid,
  input  logic [8*N_REQ-1:0]                      req_data,
  output logic [N_REQ-1:0]                        req_ready,
  output logic [7:0]                              tx_data,
  output logic                                    tx_new_data,
  input  logic                                    tx_busy,
  output logic                                    grant_valid,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] grant_idx,
  output logic                                    timeout_err
);

  localparam int unsigned IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned IW1 = IW + 1;
  localparam int unsigned BW  = $clog2(MAX_BURST + 1);
  localparam int unsigned WW  = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_BUSY = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  logic [1:0]       state, state_nx;
  logic [IW-1:0]    rr_ptr, rr_nx;
  logic [BW-1:0]    burst_cnt, burst_nx;
  logic [WW-1:0]    wd_cnt, wd_nx;

  logic [N_REQ-1:0] ready_nx;
  logic [7:0]       data_nx;
  logic             new_nx;
  logic             gvalid_nx;
  logic [IW-1:0]    gidx_nx;
  logic             timeout_nx;

  logic [7:0]       req_bytes [N_REQ];
  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic [IW1-1:0]   cand;
  logic [IW-1:0]    next_ptr;
  logic             issue;
  logic [IW-1:0]    issue_idx;

  // Split the flat request bus into one byte per requester
  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  // Round-robin search: first valid requester at or after rr_ptr, with wrap-around
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      cand = IW1'(rr_ptr) + IW1'(i);
      if (cand >= IW1'(N_REQ)) begin
        cand = cand - IW1'(N_REQ);
      end
      if (!win_found && req_valid[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  // Pointer value for the next arbitration once the current grant ends
  always_comb begin
    if (grant_idx == IW'(N_REQ - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = grant_idx + 1'b1;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nx   = state;
    rr_nx      = rr_ptr;
    burst_nx   = burst_cnt;
    wd_nx      = wd_cnt;
    ready_nx   = '0;
    data_nx    = tx_data;
    new_nx     = 1'b0;
    gvalid_nx  = grant_valid;
    gidx_nx    = grant_idx;
    timeout_nx = 1'b0;
    issue      = 1'b0;
    issue_idx  = grant_idx;

    case (state)
      IDLE: begin
        if (enable && !tx_busy && win_found) begin
          issue     = 1'b1;
          issue_idx = win_idx;
          burst_nx  = BW'(1);
          state_nx  = WAIT_BUSY;
        end
      end

      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nx = WAIT_DONE;
        end else if (wd_cnt == WW'(BUSY_TIMEOUT - 1)) begin
          // Transmitter never acknowledged the byte: abort and rotate
          wd_nx      = WW'(BUSY_TIMEOUT);
          timeout_nx = 1'b1;
          gvalid_nx  = 1'b0;
          rr_nx      = next_ptr;
          state_nx   = IDLE;
        end else begin
          wd_nx = wd_cnt + 1'b1;
        end
      end

      WAIT_DONE: begin
        if (!tx_busy) begin
          if (req_valid[grant_idx] && (burst_cnt < BW'(MAX_BURST)) && enable) begin
            issue     = 1'b1;
            issue_idx = grant_idx;
            burst_nx  = burst_cnt + 1'b1;
            state_nx  = WAIT_BUSY;
          end else begin
            gvalid_nx = 1'b0;
            rr_nx     = next_ptr;
            state_nx  = IDLE;
          end
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    // Common issue path shared by a fresh grant and a burst continuation
    if (issue) begin
      data_nx   = req_bytes[issue_idx];
      new_nx    = 1'b1;
      ready_nx  = N_REQ'(1) << issue_idx;
      gidx_nx   = issue_idx;
      gvalid_nx = 1'b1;
      wd_nx     = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      burst_cnt   <= '0;
      wd_cnt      <= '0;
      req_ready   <= '0;
      tx_data     <= '0;
      tx_new_data <= 1'b0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      rr_ptr      <= rr_nx;
      burst_cnt   <= burst_nx;
      wd_cnt      <= wd_nx;
      req_ready   <= ready_nx;
      tx_data     <= data_nx;
      tx_new_data <= new_nx;
      grant_valid <= gvalid_nx;
      grant_idx   <= gidx_nx;
      timeout_err <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Scoreboard bench for serial_tx_arbiter: stimulus queues expected grants,
// a negedge monitor pops and compares on every tx_new_data pulse.
module tb_serial_tx_arbiter;

  localparam int unsigned N_REQ        = 4;
  localparam int unsigned MAX_BURST    = 3;
  localparam int unsigned BUSY_TIMEOUT = 4;
  localparam int          FRAME        = 6;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 enable = 1'b0;
  logic [N_REQ-1:0]     req_valid;
  logic [8*N_REQ-1:0]   req_data;
  logic [N_REQ-1:0]     req_ready;
  logic [7:0]           tx_data;
  logic                 tx_new_data;
  logic                 tx_busy = 1'b0;
  logic                 grant_valid;
  logic [1:0]           grant_idx;
  logic                 timeout_err;

  always #5 clk = ~clk;

  serial_tx_arbiter #(
    .N_REQ(N_REQ), .MAX_BURST(MAX_BURST), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_data(tx_data), .tx_new_data(tx_new_data), .tx_busy(tx_busy),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .timeout_err(timeout_err)
  );

  typedef struct {
    int idx;
    int data;
    int gap;   // negedges from tx_busy fall to pulse; 0 = not checked
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  logic [7:0] rq [N_REQ][$];
  int vectors = 0;
  int miscompares = 0;
  int ng = 0;
  int fall_ng = -100;
  int last_nd_ng = 0;
  int timeouts_seen = 0;
  int rem = 0;
  bit tx_dead = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function void refresh();
    for (int i = 0; i < int'(N_REQ); i++) begin
      req_valid[i]       = (rq[i].size() != 0);
      req_data[8*i +: 8] = (rq[i].size() != 0) ? rq[i][0] : 8'h00;
    end
  endfunction

  function bit all_empty();
    for (int i = 0; i < int'(N_REQ); i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push(input int idx, input int data, input int gap);
    exp_t x;
    x.idx = idx; x.data = data; x.gap = gap;
    exp_q.push_back(x);
  endtask

  task automatic load(input int idx, input logic [7:0] b);
    rq[idx].push_back(b);
    refresh();
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && all_empty() && tx_busy == 1'b0 &&
             grant_valid == 1'b0 && rem == 0)) begin
      tick(1);
      k++;
      if (k > budget) begin
        chk({name, "_drain_bound"}, 32'(exp_q.size()), 0);
        exp_q.delete();
        break;
      end
    end
    tick(1);
  endtask

  // Monitor, requester model and serial_tx model, all on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      ng++;
      if (tx_new_data === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_new_data", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("grant_idx", 32'(grant_idx), e.idx);
          chk("tx_data", 32'(tx_data), e.data);
          chk("req_ready", 32'(req_ready), 1 << e.idx);
          chk("grant_valid", 32'(grant_valid), 1);
          if (e.gap != 0) chk("busy_gap", ng - fall_ng, e.gap);
        end
        last_nd_ng = ng;
      end else if (req_ready !== '0) begin
        chk("ready_without_new_data", 32'(req_ready), 0);
      end
      if (timeout_err === 1'b1) begin
        timeouts_seen++;
        chk("timeout_delay", ng - last_nd_ng, BUSY_TIMEOUT);
        chk("timeout_grant_valid", 32'(grant_valid), 0);
      end
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (req_ready[i] === 1'b1 && rq[i].size() > 0) void'(rq[i].pop_front());
      end
      refresh();
      if (tx_new_data === 1'b1 && !tx_dead) begin
        tx_busy = 1'b1;
        rem     = FRAME;
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          tx_busy = 1'b0;
          fall_ng = ng;
        end
      end
    end
  end

  // Hard stop in case the stimulus itself gets stuck
  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    int k;
    refresh();
    tick(3);
    chk("reset_tx_new_data", 32'(tx_new_data), 0);
    chk("reset_grant_valid", 32'(grant_valid), 0);
    chk("reset_req_ready", 32'(req_ready), 0);
    chk("reset_tx_data", 32'(tx_data), 0);
    chk("reset_grant_idx", 32'(grant_idx), 0);
    chk("reset_timeout_err", 32'(timeout_err), 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    tick(2);

    // 1: all four valid -> strict rotation 0,1,2,3
    push(0, 'hA1, 0); push(1, 'hB2, 2); push(2, 'hC3, 2); push(3, 'hD4, 2);
    load(0, 8'hA1); load(1, 8'hB2); load(2, 8'hC3); load(3, 8'hD4);
    tick(1);
    chk("t1_latency", 32'(tx_new_data), 1);
    wait_drain("t1", 200);

    // 2: single requester with 5 bytes -> burst of 3, re-grant for 2
    push(2, 'h10, 0); push(2, 'h11, 1); push(2, 'h12, 1); push(2, 'h13, 2); push(2, 'h14, 1);
    for (int i = 0; i < 5; i++) load(2, 8'(8'h10 + i));
    wait_drain("t2", 200);

    // 3: park rr_ptr at 2, then req 1+3 -> 3 first; then req 1+2 proves rr_ptr is 2 again
    push(1, 'h31, 0);
    load(1, 8'h31);
    wait_drain("t3a", 100);
    push(3, 'h33, 0); push(1, 'h32, 2);
    load(1, 8'h32); load(3, 8'h33);
    wait_drain("t3b", 100);
    push(2, 'h35, 0); push(1, 'h34, 2);
    load(1, 8'h34); load(2, 8'h35);
    wait_drain("t3c", 100);

    // 4: transmitter never raises busy -> two aborts, both bytes still handed over once
    tx_dead = 1'b1;
    push(0, 'h41, 0); push(0, 'h42, 0);
    load(0, 8'h41); load(0, 8'h42);
    wait_drain("t4", 100);
    chk("t4_timeouts", 32'(timeouts_seen), 2);
    tx_dead = 1'b0;

    // 5: reset while a frame is in flight; no grant until busy drops
    push(2, 'h51, 0);
    load(2, 8'h51); load(2, 8'h52); load(2, 8'h53);
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin tick(1); k++; end
    chk("t5_first_byte", 32'(exp_q.size()), 0);
    tick(3);
    rst_n = 1'b0;
    rem   = 12;
    #1;
    chk("t5_rst_tx_new_data", 32'(tx_new_data), 0);
    chk("t5_rst_grant_valid", 32'(grant_valid), 0);
    chk("t5_rst_req_ready", 32'(req_ready), 0);
    chk("t5_rst_tx_data", 32'(tx_data), 0);
    chk("t5_rst_grant_idx", 32'(grant_idx), 0);
    chk("t5_rst_timeout_err", 32'(timeout_err), 0);
    tick(2);
    rst_n = 1'b1;
    push(2, 'h52, 1); push(2, 'h53, 1);
    wait_drain("t5", 200);

    // 6: enable low holds everything off; enable high grants next cycle, from rr_ptr=3
    enable = 1'b0;
    load(0, 8'h61); load(1, 8'h62); load(2, 8'h63); load(3, 8'h64);
    tick(100);
    chk("t6_no_grant", 32'(grant_valid), 0);
    push(3, 'h64, 0); push(0, 'h61, 2); push(1, 'h62, 2); push(2, 'h63, 2);
    enable = 1'b1;
    tick(1);
    chk("t6_latency", 32'(tx_new_data), 1);
    wait_drain("t6", 200);

    chk("total_timeouts", 32'(timeouts_seen), 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
